// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;
   localparam int WIDTH_DEF = 32;
   localparam int CNT_W_DEF = 6;

   typedef enum logic [2:0] {IDLE, MULT, DIV, FIXUP, DONE} stateT;

   // Booth recoding of {q[0], q[-1]}
   localparam logic [1:0] BOOTH_ADD = 2'b01;
   localparam logic [1:0] BOOTH_SUB = 2'b10;
endpackage

// File: rtl/muldiv_if.sv
// Control-side bus of the multiply/divide unit: start strobes, operands, MTHI/MTLO, results.
interface muldiv_if #(parameter int WIDTH = 32);
   logic             mult_start;
   logic             div_start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;
   logic             busy;
   logic             done;
   logic             div_zero;

   modport master (output mult_start, div_start, a_in, b_in, hi_we, lo_we,
                   input  hi_out, lo_out, busy, done, div_zero);
   modport slave  (input  mult_start, div_start, a_in, b_in, hi_we, lo_we,
                   output hi_out, lo_out, busy, done, div_zero);
endinterface

// File: rtl/muldiv_divstep.sv
// One restoring-division step on magnitudes: shift in the next dividend bit, trial-subtract.
module muldiv_divstep #(parameter int WIDTH = 32) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] quo_out
);
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   always_comb begin
      shifted = {rem_in, quo_in[WIDTH-1]};
      diff    = shifted - {1'b0, divisor};
      if (!diff[WIDTH]) begin
         rem_out = diff[WIDTH-1:0];
         quo_out = {quo_in[WIDTH-2:0], 1'b1};
      end else begin
         rem_out = shifted[WIDTH-1:0];
         quo_out = {quo_in[WIDTH-2:0], 1'b0};
      end
   end
endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative signed MULT (radix-2 Booth) / DIV (restoring) with HI/LO and sequencing FSM.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic   clk,
   input  logic   reset,
   muldiv_if.slave bus
);
   stateT              state, stateNxt;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   hiReg, loReg;
   logic [WIDTH-1:0]   mcand;
   // {acc[WIDTH:0], multiplier[WIDTH-1:0], q[-1]}; acc has a guard bit so -2^(W-1) cannot overflow
   logic [2*WIDTH+1:0] prod, prodNxt;
   logic [WIDTH:0]     acc, accNew;
   logic [WIDTH-1:0]   rem, quo, divisor, remOut, quoOut;
   logic               negQuo, negRem, dzFlag;
   logic               lastStep;

   wire [WIDTH-1:0] absA = bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in;
   wire [WIDTH-1:0] absB = bus.b_in[WIDTH-1] ? -bus.b_in : bus.b_in;

   muldiv_divstep #(.WIDTH(WIDTH)) uDivStep (
      .rem_in (rem),
      .quo_in (quo),
      .divisor(divisor),
      .rem_out(remOut),
      .quo_out(quoOut)
   );

   always_comb begin
      acc = prod[2*WIDTH+1:WIDTH+1];
      case (prod[1:0])
         BOOTH_ADD: accNew = acc + {mcand[WIDTH-1], mcand};
         BOOTH_SUB: accNew = acc - {mcand[WIDTH-1], mcand};
         default:   accNew = acc;
      endcase
      prodNxt = {accNew[WIDTH], accNew, prod[WIDTH:1]};
   end

   assign lastStep = (cnt == CNT_W'(WIDTH-1));

   always_comb begin
      stateNxt = state;
      case (state)
         IDLE: begin
            if (bus.mult_start)     stateNxt = MULT;
            else if (bus.div_start) stateNxt = (bus.b_in == '0) ? DONE : DIV;
         end
         MULT:    if (lastStep) stateNxt = DONE;
         DIV:     if (lastStep) stateNxt = FIXUP;
         FIXUP:   stateNxt = DONE;
         DONE:    stateNxt = IDLE;
         default: stateNxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= stateNxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0; hiReg <= '0; loReg <= '0; mcand <= '0; prod <= '0;
         rem <= '0; quo <= '0; divisor <= '0;
         negQuo <= 1'b0; negRem <= 1'b0; dzFlag <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.mult_start) begin
                  mcand <= bus.a_in;
                  prod  <= {{(WIDTH+1){1'b0}}, bus.b_in, 1'b0};
                  cnt   <= '0;
               end else if (bus.div_start) begin
                  if (bus.b_in == '0) begin
                     dzFlag <= 1'b1;
                  end else begin
                     rem     <= '0;
                     quo     <= absA;
                     divisor <= absB;
                     negQuo  <= bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
                     negRem  <= bus.a_in[WIDTH-1];
                     cnt     <= '0;
                  end
               end else begin
                  if (bus.hi_we) hiReg <= bus.a_in;
                  if (bus.lo_we) loReg <= bus.a_in;
               end
            end
            MULT: begin
               prod <= prodNxt;
               cnt  <= cnt + 1'b1;
               if (lastStep) {hiReg, loReg} <= prodNxt[2*WIDTH:1];
            end
            DIV: begin
               rem <= remOut;
               quo <= quoOut;
               cnt <= cnt + 1'b1;
            end
            FIXUP: begin
               loReg <= negQuo ? -quo : quo;
               hiReg <= negRem ? -rem : rem;
            end
            DONE:    dzFlag <= 1'b0;
            default: ;
         endcase
      end
   end

   assign bus.hi_out   = hiReg;
   assign bus.lo_out   = loReg;
   assign bus.busy     = (state == MULT) || (state == DIV) || (state == FIXUP);
   assign bus.done     = (state == DONE);
   assign bus.div_zero = (state == DONE) && dzFlag;
endmodule
